// File: rtl/buff_en_mc_pkg.sv
// Shared token types and channel-index helpers for the multi-channel token buffer.
package buff_en_mc_pkg;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_CH_DFLT = 4;
  localparam int CH_W_DFLT   = ch_w(NUM_CH_DFLT);

  typedef logic [CH_W_DFLT-1:0] ch_idx_t;

  typedef struct packed {
    logic       v;
    logic       a;
    logic       c;
    logic       r;
    logic [6:0] i;
    logic [31:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

endpackage

// File: rtl/buff_en_mc_ring_buff_ch.sv
// One channel's ring buffer; head is combinational, writes gated by token valid and space.
// A write into a full buffer is accepted only when the head is read in the same cycle.
module buff_en_mc_ring_buff_ch
  import buff_en_mc_pkg::*;
#(
  parameter int  DEPTH_BUFF = 16,
  parameter type TYPE_FWRD  = FTk_t,
  localparam int WIDTH      = $clog2(DEPTH_BUFF)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           I_We,
  input  logic           I_Re,
  input  TYPE_FWRD       I_FTk,
  output TYPE_FWRD       O_FTk,
  output logic [WIDTH:0] O_Num,
  output logic           O_Empty,
  output logic           O_Full
);

  TYPE_FWRD         mem [DEPTH_BUFF];
  logic [WIDTH-1:0] wr_ptr;
  logic [WIDTH-1:0] rd_ptr;
  logic [WIDTH:0]   num;
  logic             we;

  assign O_Full  = (num == (WIDTH+1)'(DEPTH_BUFF));
  assign O_Empty = (num == '0);
  assign O_Num   = num;
  assign O_FTk   = mem[rd_ptr];
  assign we      = I_We & I_FTk.v & (~O_Full | I_Re);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      num    <= '0;
    end else begin
      if (we)   wr_ptr <= wr_ptr + 1'b1;
      if (I_Re) rd_ptr <= rd_ptr + 1'b1;
      case ({we, I_Re})
        2'b10:   num <= num + 1'b1;
        2'b01:   num <= num - 1'b1;
        default: num <= num;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr] <= I_FTk;
  end

endmodule

// File: rtl/buff_en_mc.sv
// NUM_CH ring buffers merged onto one output via round-robin (or fixed priority when
// BUFF_EN_MC_PRIO_EN is defined), with per-channel Nack hysteresis and downstream stall.
module buff_en_mc
  import buff_en_mc_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  DEPTH_BUFF = 16,
  parameter int  THRESH_HI  = DEPTH_BUFF - 3,
  parameter int  THRESH_LO  = 4,
  parameter type TYPE_FWRD  = FTk_t,
  localparam int CH_W       = ch_w(NUM_CH),
  localparam int WIDTH      = $clog2(DEPTH_BUFF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] I_We,
  input  logic              I_Re,
  input  TYPE_FWRD          I_FTk [NUM_CH],
  output BTk_t              O_BTk [NUM_CH],
  output TYPE_FWRD          O_FTk,
  output logic [CH_W-1:0]   O_Ch,
  input  BTk_t              I_BTk,
  output logic [NUM_CH-1:0] O_Empty,
  output logic [NUM_CH-1:0] O_Full
);

  TYPE_FWRD          head [NUM_CH];
  logic [WIDTH:0]    num  [NUM_CH];
  logic [NUM_CH-1:0] rd_sel;
  logic [NUM_CH-1:0] r_nack;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              do_rd;
  logic              r_stop;
  logic              prev_n;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    buff_en_mc_ring_buff_ch #(
      .DEPTH_BUFF(DEPTH_BUFF),
      .TYPE_FWRD (TYPE_FWRD)
    ) u_buff (
      .clock  (clock),
      .reset  (reset),
      .I_We   (I_We[c]),
      .I_Re   (rd_sel[c]),
      .I_FTk  (I_FTk[c]),
      .O_FTk  (head[c]),
      .O_Num  (num[c]),
      .O_Empty(O_Empty[c]),
      .O_Full (O_Full[c])
    );

    assign rd_sel[c] = do_rd & (grant == CH_W'(c));
    assign O_BTk[c]  = '{n: r_nack[c], t: I_BTk.t, v: I_BTk.v, c: I_BTk.c};
  end

`ifdef BUFF_EN_MC_PRIO_EN
  // Descending scan so the lowest-index non-empty channel is the final assignment.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!O_Empty[i]) begin
        grant = CH_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] cand;

  // Descending offset scan: the nearest channel after last_grant wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (!O_Empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)      last_grant <= CH_W'(NUM_CH - 1);
    else if (do_rd) last_grant <= grant;
  end
`endif

  assign do_rd = I_Re & ~r_stop & found;
  assign O_FTk = do_rd ? head[grant] : '0;
  assign O_Ch  = do_rd ? grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stop <= 1'b0;
      prev_n <= 1'b0;
      r_nack <= '0;
    end else begin
      prev_n <= I_BTk.n;
      // Release needs Nack low both now and in the previous cycle.
      if (I_BTk.n)      r_stop <= 1'b1;
      else if (!prev_n) r_stop <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (num[c] >= (WIDTH+1)'(THRESH_HI))     r_nack[c] <= 1'b1;
        else if (num[c] < (WIDTH+1)'(THRESH_LO)) r_nack[c] <= 1'b0;
      end
    end
  end

endmodule
